noise_generator: RTL and testbench
==================================

NOISE_GENERATOR -- requirements
Module: noise_generator

Interface
REQ-001 Parameter CLK_PER_US, default 500: clock cycles per microsecond (500 MHz clock).
REQ-002 Parameter LFSR_SEED, default 32'hACE12468: LFSR reset value; SHALL be nonzero.
REQ-003 Port CLK, input, 1: single system clock; all logic on rising edge.
REQ-004 Port RESET, input, 1: reset, synchronous and active-high.
REQ-005 Port T_IMPULSE, input, 10: pulse length in microseconds, 1..1023 (operational range 60..650).
REQ-006 Port SIGN_START_GEN, input, 1: start request; its rising edge triggers a pulse.
REQ-007 Port OUT_REG_READY, input, 1: downstream output register ready.
REQ-008 Port SIGN_START_CALC, output, 1: one-cycle strobe marking the first noise sample.
REQ-009 Port SIGN_STOP_CALC, output, 1: one-cycle strobe marking the end of the pulse.
REQ-010 Port NOISE_OUT, output, 12: noise sample, unsigned.

Function
REQ-011 The module SHALL have two states, IDLE and GEN, and SHALL register SIGN_START_GEN once to detect rising edges (previous 0, current 1).
REQ-012 In IDLE, a rising edge SHALL start a pulse only when OUT_REG_READY=1 and T_IMPULSE!=0 in the same cycle; otherwise the edge is dropped, not queued.
REQ-013 On start, the module SHALL latch N = T_IMPULSE*CLK_PER_US (24-bit unsigned, no overflow for 1023*500) and enter GEN on the next cycle.
REQ-014 In GEN, NOISE_OUT SHALL carry a new sample every cycle for exactly N cycles; SIGN_START_CALC SHALL be 1 only in the first of these cycles.
REQ-015 In the cycle after the last sample, SIGN_STOP_CALC SHALL be 1 for one cycle, NOISE_OUT SHALL be 0, and the state SHALL return to IDLE.
REQ-016 An edge arriving in that SIGN_STOP_CALC cycle SHALL be evaluated as in IDLE (back-to-back pulses allowed).
REQ-017 Start edges and changes to T_IMPULSE or OUT_REG_READY during GEN SHALL be ignored.
REQ-018 NOISE_OUT SHALL be 0 in IDLE.
REQ-019 Noise source: 32-bit Galois LFSR, right-shift, feedback mask 32'h80200003 (x^32+x^22+x^2+x+1), advanced once per GEN cycle only.
REQ-020 The LFSR SHALL hold its value between pulses and SHALL NOT be reseeded except by RESET.
REQ-021 Default sample: NOISE_OUT = LFSR bits [31:20] of the state in effect for that cycle (first sample = state after one advance from the held value).

Reset
REQ-022 With RESET=1 at a clock edge: state IDLE, LFSR = LFSR_SEED, counter 0, edge register 0, SIGN_START_CALC=0, SIGN_STOP_CALC=0, NOISE_OUT=0.
REQ-023 RESET during GEN SHALL abort the pulse immediately with no SIGN_STOP_CALC strobe.
REQ-024 After RESET is released, SIGN_START_GEN already high SHALL NOT count as an edge.

Configuration
REQ-025 Macro NOISE_GEN_GAUSS_EN: when defined, NOISE_OUT SHALL be the sum of the four 12-bit LFSR slices [11:0], [19:8], [27:16] and [31:20], as a 14-bit sum, right-shifted by 2 (approximately Gaussian). It SHALL keep the same cycle timing as REQ-014/015.
REQ-026 Without NOISE_GEN_GAUSS_EN, REQ-021 applies and no adder logic SHALL be synthesized.

Verification
REQ-027 Reset, T_IMPULSE=10, OUT_REG_READY=1, one rising edge of SIGN_START_GEN -> SIGN_START_CALC pulses once, then exactly 5000 nonzero-capable samples, then one SIGN_STOP_CALC cycle, then NOISE_OUT=0.
REQ-028 From reset, the first sample SHALL equal bits [31:20] of one Galois step of 32'hACE12468; a reference model SHALL match the full sequence with the macro undefined.
REQ-029 OUT_REG_READY=0 at the edge -> no strobes, NOISE_OUT stays 0; a later edge with OUT_REG_READY=1 starts normally.
REQ-030 SIGN_START_GEN toggling every 5 cycles during GEN, T_IMPULSE changed 10->60 mid-pulse -> pulse length stays 5000 cycles; the next accepted pulse is 30000 cycles.
REQ-031 RESET asserted at sample 100 -> outputs 0 the next cycle, no SIGN_STOP_CALC; LFSR back to seed (the next pulse repeats the first sequence).
REQ-032 T_IMPULSE=0 with an edge -> no pulse; T_IMPULSE=1023 -> 511500 samples. With NOISE_GEN_GAUSS_EN, sample mean over 5000 samples is within 2048±64.

Source files
------------

// File: rtl/noise_generator.sv
// Pulse-gated noise source: on an accepted start edge, emits T_IMPULSE*CLK_PER_US LFSR-derived samples.
// Define NOISE_GEN_GAUSS_EN to replace the raw LFSR slice with a four-slice sum (approximately Gaussian).
module noise_generator #(
  parameter int unsigned CLK_PER_US = 500,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [9:0]  T_IMPULSE,
  input  logic        SIGN_START_GEN,
  input  logic        OUT_REG_READY,
  output logic        SIGN_START_CALC,
  output logic        SIGN_STOP_CALC,
  output logic [11:0] NOISE_OUT
);

  typedef enum logic {IDLE, GEN} state_t;

  localparam logic [31:0] FEEDBACK_MASK = 32'h80200003;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, lfsr_step;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] n_cycles;
  logic        start_q;
  logic        armed_q;
  logic        start_edge;
  logic        accept;
  logic [11:0] sample;
  logic [11:0] noise_d;
  logic        start_calc_d;
  logic        stop_calc_d;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? FEEDBACK_MASK : 32'h0);

`ifdef NOISE_GEN_GAUSS_EN
  logic [13:0] slice_sum;
  assign slice_sum = 14'(lfsr_step[11:0])  + 14'(lfsr_step[19:8])
                   + 14'(lfsr_step[27:16]) + 14'(lfsr_step[31:20]);
  assign sample    = slice_sum[13:2];
`else
  assign sample    = lfsr_step[31:20];
`endif

  // 1023 * 500 fits comfortably in 24 bits.
  assign n_cycles = 24'(T_IMPULSE) * 24'(CLK_PER_US);

  // armed_q masks the first cycle after reset so a level already high is not an edge.
  assign start_edge = armed_q & ~start_q & SIGN_START_GEN;
  assign accept     = start_edge & OUT_REG_READY & (T_IMPULSE != 10'd0);

  // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    noise_d      = 12'd0;
    start_calc_d = 1'b0;
    stop_calc_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = GEN;
          lfsr_d       = lfsr_step;
          cnt_d        = n_cycles - 24'd1;
          noise_d      = sample;
          start_calc_d = 1'b1;
        end
      end
      GEN: begin
        if (cnt_q != 24'd0) begin
          lfsr_d  = lfsr_step;
          cnt_d   = cnt_q - 24'd1;
          noise_d = sample;
        end else begin
          // The stop cycle is already IDLE, so an edge arriving here is evaluated normally.
          state_d     = IDLE;
          stop_calc_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      lfsr_q          <= LFSR_SEED;
      cnt_q           <= 24'd0;
      start_q         <= 1'b0;
      armed_q         <= 1'b0;
      SIGN_START_CALC <= 1'b0;
      SIGN_STOP_CALC  <= 1'b0;
      NOISE_OUT       <= 12'd0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      cnt_q           <= cnt_d;
      start_q         <= SIGN_START_GEN;
      armed_q         <= 1'b1;
      SIGN_START_CALC <= start_calc_d;
      SIGN_STOP_CALC  <= stop_calc_d;
      NOISE_OUT       <= noise_d;
    end
  end

endmodule

// File: tb/tb_noise_generator.sv
// Self-checking bench for noise_generator: table vectors, directed corner sequences and random pulses vs. a model.
module tb_noise_generator;

  localparam int unsigned CLK_PER_US = 500;
  localparam logic [31:0] SEED       = 32'hACE12468;
  localparam logic [31:0] POLY       = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  t_imp = 10'd0;
  logic        start_gen = 1'b0;
  logic        ready = 1'b0;
  logic        start_calc;
  logic        stop_calc;
  logic [11:0] noise;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_lfsr;
  longint      sample_sum = 0;
  longint      sample_n = 0;

  noise_generator #(.CLK_PER_US(CLK_PER_US), .LFSR_SEED(SEED)) dut (
    .CLK            (clk),
    .RESET          (rst),
    .T_IMPULSE      (t_imp),
    .SIGN_START_GEN (start_gen),
    .OUT_REG_READY  (ready),
    .SIGN_START_CALC(start_calc),
    .SIGN_STOP_CALC (stop_calc),
    .NOISE_OUT      (noise)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL global_timeout got=expired exp=finished");
    $fatal(1, "timeout");
  end

  // Galois step written as polynomial division by x: halve, fold the dropped bit back through the mask.
  function automatic logic [31:0] galois_step(input logic [31:0] s);
    logic [31:0] half;
    half = s / 32'd2;
    return (s % 32'd2 == 32'd1) ? (half ^ POLY) : half;
  endfunction

  function automatic logic [11:0] model_sample(input logic [31:0] s);
`ifdef NOISE_GEN_GAUSS_EN
    int sum;
    sum = int'(s[11:0]) + int'(s[19:8]) + int'(s[27:16]) + int'(s[31:20]);
    return 12'(sum / 4);
`else
    return s[31:20];
`endif
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic give_edge();
    start_gen = 1'b1;
    tick();
    start_gen = 1'b0;
  endtask

  // Called in the window showing the first sample; follows the pulse to its stop strobe.
  task automatic run_pulse(input int exp_len, input bit toggle, input bit b2b);
    int          len;
    int          n_bad;
    int          n_strobe_bad;
    logic [11:0] exp_s;
    len = 0;
    n_bad = 0;
    n_strobe_bad = 0;
    while (stop_calc !== 1'b1 && len < exp_len + 8) begin
      model_lfsr = galois_step(model_lfsr);
      exp_s = model_sample(model_lfsr);
      if (noise !== exp_s) n_bad++;
      if (start_calc !== (len == 0)) n_strobe_bad++;
      sample_sum += longint'(noise);
      sample_n++;
      len++;
      if (toggle) begin
        if (len % 5 == 0) start_gen = ~start_gen;
        if (len == 1000) ready = 1'b0;
        if (len == 2500) t_imp = 10'd60;
        if (len == 4000) ready = 1'b1;
        if (len >= exp_len - 10) start_gen = 1'b0;
      end
      tick();
    end
    check("pulse_len", len, exp_len);
    check("pulse_data_bad_count", n_bad, 0);
    check("start_calc_bad_count", n_strobe_bad, 0);
    check("stop_strobe", stop_calc, 1);
    check("stop_noise_zero", noise, 0);
    if (b2b) begin
      give_edge();
    end else begin
      tick();
      check("idle_stop_low", stop_calc, 0);
      check("idle_noise_zero", noise, 0);
    end
  endtask

  typedef struct {
    logic [9:0] t;
    logic       rdy;
    bit         accept;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int saw;
    int t_r;
    int r_r;
    bit exp_acc;

    vecs[0] = '{t: 10'd0, rdy: 1'b1, accept: 1'b0};
    vecs[1] = '{t: 10'd2, rdy: 1'b0, accept: 1'b0};
    vecs[2] = '{t: 10'd1, rdy: 1'b1, accept: 1'b1};
    vecs[3] = '{t: 10'd0, rdy: 1'b0, accept: 1'b0};
    vecs[4] = '{t: 10'd2, rdy: 1'b1, accept: 1'b1};

    // Reset with start already high: releasing reset must not create an edge.
    rst = 1'b1; start_gen = 1'b1; ready = 1'b1; t_imp = 10'd1;
    tick(); tick();
    check("reset_noise", noise, 0);
    check("reset_start_calc", start_calc, 0);
    check("reset_stop_calc", stop_calc, 0);
    rst = 1'b0;
    model_lfsr = SEED;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (start_calc === 1'b1 || noise !== 12'd0) saw++;
    end
    check("no_edge_after_reset", saw, 0);
    start_gen = 1'b0;
    tick();

    // Basic 10 us pulse, first sample from the seed, then a back-to-back pulse.
    t_imp = 10'd10;
    ready = 1'b1;
    give_edge();
    check("first_start_calc", start_calc, 1);
    check("first_sample", noise, model_sample(galois_step(SEED)));
    sample_sum = 0;
    sample_n = 0;
    run_pulse(5000, 1'b0, 1'b1);
`ifdef NOISE_GEN_GAUSS_EN
    check("gauss_mean_in_range",
          ((sample_sum / sample_n) >= 1984 && (sample_sum / sample_n) <= 2112), 1);
`endif
    check("b2b_start_calc", start_calc, 1);
    run_pulse(5000, 1'b0, 1'b0);

    // Acceptance table: T, ready, expected acceptance.
    foreach (vecs[i]) begin
      t_imp = vecs[i].t;
      ready = vecs[i].rdy;
      give_edge();
      check($sformatf("vec%0d_start_calc", i), start_calc, vecs[i].accept);
      if (vecs[i].accept) begin
        run_pulse(int'(vecs[i].t) * CLK_PER_US, 1'b0, 1'b0);
      end else begin
        check($sformatf("vec%0d_noise_zero", i), noise, 0);
        tick();
        check($sformatf("vec%0d_stop_low", i), stop_calc, 0);
      end
    end

    // Start toggling and T/ready changes during GEN are ignored; new T applies next pulse.
    t_imp = 10'd10;
    ready = 1'b1;
    give_edge();
    check("toggle_start_calc", start_calc, 1);
    run_pulse(5000, 1'b1, 1'b0);
    check("t_after_toggle", t_imp, 60);
    give_edge();
    check("long_start_calc", start_calc, 1);
    run_pulse(30000, 1'b0, 1'b0);

    // Long pulse (T=1023) aborted by reset at sample 100; next pulse replays the seed sequence.
    t_imp = 10'd1023;
    give_edge();
    check("max_t_start_calc", start_calc, 1);
    saw = 0;
    for (int i = 1; i <= 100; i++) begin
      model_lfsr = galois_step(model_lfsr);
      if (noise !== model_sample(model_lfsr) || stop_calc !== 1'b0) saw++;
      if (i < 100) tick();
    end
    check("pre_abort_bad_count", saw, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_noise_zero", noise, 0);
    check("abort_no_stop", stop_calc, 0);
    check("abort_start_calc", start_calc, 0);
    model_lfsr = SEED;
    tick();
    check("post_abort_stop_low", stop_calc, 0);
    t_imp = 10'd1;
    give_edge();
    check("replay_start_calc", start_calc, 1);
    check("replay_first_sample", noise, model_sample(galois_step(SEED)));
    run_pulse(500, 1'b0, 1'b0);

    // Random acceptance decisions and short pulses against the model.
    for (int k = 0; k < 8; k++) begin
      t_r = int'($urandom_range(0, 3));
      r_r = int'($urandom_range(0, 1));
      exp_acc = (r_r == 1) && (t_r != 0);
      t_imp = 10'(t_r);
      ready = 1'(r_r);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      give_edge();
      check($sformatf("rand%0d_start_calc", k), start_calc, exp_acc);
      if (exp_acc) begin
        run_pulse(t_r * CLK_PER_US, 1'b0, 1'b0);
      end else begin
        check($sformatf("rand%0d_noise_zero", k), noise, 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
